// File: rtl/sqrt_iter_ctrl.sv
// ============================================================================
// sqrt_iter_ctrl : restoring square-root sequencer, one root bit per cycle.
// Optional: SQRT_STICKY_EN adds out_sticky (remainder non-zero).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_iter_ctrl #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_radicand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH/2-1:0]   out_root,
  output logic [WIDTH/2:0]     out_rem,
  output logic                 busy
`ifdef SQRT_STICKY_EN
  ,
  output logic                 out_sticky
`endif
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("sqrt_iter_ctrl: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_rad;
  logic [N+1:0]       r_rem;
  logic [N-1:0]       r_root;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [N+1:0]       w_rem_sh;
  logic [N+1:0]       w_trial;
  logic               w_borrow;
  logic [N+1:0]       w_rem_nxt;
  logic [N-1:0]       w_root_nxt;
  logic               w_unused_rem_msb;

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_last     = (r_state == ST_CALC) && (r_cnt == C_LAST);

  // Partial remainder never exceeds N bits before the shift, so its top two
  // bits can be dropped when bringing down the next radicand pair.
  assign w_rem_sh   = {r_rem[N-1:0], r_rad[WIDTH-1:WIDTH-2]};
  assign w_trial    = {r_root, 2'b01};
  assign w_borrow   = (w_rem_sh < w_trial);
  assign w_rem_nxt  = w_borrow ? w_rem_sh : (w_rem_sh - w_trial);
  assign w_root_nxt = {r_root[N-2:0], ~w_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (r_cnt == C_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_rad  <= in_radicand;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else if (r_state == ST_CALC) begin
      r_rad  <= {r_rad[WIDTH-3:0], 2'b00};
      r_rem  <= w_rem_nxt;
      r_root <= w_root_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign out_root         = r_root;
  assign out_rem          = r_rem[N:0];
  assign w_unused_rem_msb = r_rem[N+1];

`ifdef SQRT_STICKY_EN
  logic r_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= 1'b0;
    end else if (w_last) begin
      r_sticky <= |w_rem_nxt;
    end
  end

  assign out_sticky = r_sticky;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sqrt_iter_ctrl.sv
// ============================================================================
// tb_sqrt_iter_ctrl : directed vector bench for sqrt_iter_ctrl (WIDTH=24).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sqrt_iter_ctrl;

  localparam int WIDTH = 24;
  localparam int N     = WIDTH / 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_radicand;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_root;
  logic [N:0]       out_rem;
  logic             busy;
`ifdef SQRT_STICKY_EN
  logic             out_sticky;
`endif

  sqrt_iter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_radicand (in_radicand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_root    (out_root),
    .out_rem     (out_rem),
    .busy        (busy)
`ifdef SQRT_STICKY_EN
    ,
    .out_sticky  (out_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] rad;
    logic [N-1:0]     root;
    logic [N:0]       rem;
  } vec_t;

  vec_t vecs[12];
  int   n_vec;
  int   n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [N-1:0] e_root, input logic [N:0] e_rem);
    chk({tag, "_root"}, 32'(out_root), 32'(e_root));
    chk({tag, "_rem"},  32'(out_rem),  32'(e_rem));
`ifdef SQRT_STICKY_EN
    chk({tag, "_sticky"}, 32'(out_sticky), 32'(e_rem != '0));
`endif
  endtask

  // One complete operation: accept, count edges to out_valid, optional
  // back-pressure in DONE, handshake, and check the return to IDLE.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] rad,
                        input logic [N-1:0] e_root, input logic [N:0] e_rem,
                        input int hold, input bit garble);
    int edges;
    @(negedge clk);
    out_ready   = (hold == 0);
    in_valid    = 1'b1;
    in_radicand = rad;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (garble) in_radicand = WIDTH'($urandom);
    else        in_valid = 1'b0;
    chk({tag, "_busy_calc"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_calc"}, 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (garble) in_radicand = WIDTH'($urandom);
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(edges), 32'(N));
    chk_result(tag, e_root, e_rem);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk_result({tag, "_hold"}, e_root, e_rem);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{24'd144,      12'd12,   13'd0};
    vecs[1]  = '{24'd16777215, 12'd4095, 13'd8190};
    vecs[2]  = '{24'd2,        12'd1,    13'd1};
    vecs[3]  = '{24'd0,        12'd0,    13'd0};
    vecs[4]  = '{24'd1000,     12'd31,   13'd39};
    vecs[5]  = '{24'd81,       12'd9,    13'd0};
    vecs[6]  = '{24'd3,        12'd1,    13'd2};
    vecs[7]  = '{24'd4194304,  12'd2048, 13'd0};
    vecs[8]  = '{24'd16769025, 12'd4095, 13'd0};
    vecs[9]  = '{24'd16769024, 12'd4094, 13'd8188};
    vecs[10] = '{24'd1000000,  12'd1000, 13'd0};
    vecs[11] = '{24'd99,       12'd9,    13'd18};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_radicand = '0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_result("rst", '0, '0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].rad, vecs[i].root, vecs[i].rem, 0, 1'b0);
    end

    run_op("backpressure", 24'd1000, 12'd31, 13'd39, 5, 1'b0);
    run_op("garble", 24'd144, 12'd12, 13'd0, 0, 1'b1);

    // Async reset in the 6th CALC cycle discards the operation.
    @(negedge clk);
    in_valid    = 1'b1;
    in_radicand = 24'd1000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk_result("midrst", '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    run_op("after_rst", 24'd81, 12'd9, 13'd0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
